// File: rtl/core_pkg.sv
// Shared core definitions: MEM-stage handshake FSM states and writeback
// result-select encodings.
package core_pkg;

  typedef enum logic {
    ST_IDLE = 1'b0,
    ST_WAIT = 1'b1
  } mem_state_t;

  localparam logic [1:0] RES_ALU  = 2'b00;
  localparam logic [1:0] RES_LOAD = 2'b01;
  localparam logic [1:0] RES_PC4  = 2'b10;
  localparam logic [1:0] RES_IMM  = 2'b11;

endpackage

// File: rtl/dmem_ctrl.sv
// Data-memory request/acknowledge handshake for the MEM stage.
// Holds the request until ack and stalls the pipeline meanwhile.
module dmem_ctrl
  import core_pkg::*;
(
  input  logic clk,
  input  logic reset,
  input  logic access,
  input  logic misalign_req,
  input  logic dmem_ack,
  output logic dmem_req,
  output logic mem_stall,
  output logic mem_misalign,
  output logic done
);

  mem_state_t state, state_next;

  always_ff @(posedge clk) begin
    if (reset) state <= ST_IDLE;
    else       state <= state_next;
  end

  always_comb begin
    state_next = state;
    case (state)
      ST_IDLE: if (access && !misalign_req && !dmem_ack) state_next = ST_WAIT;
      ST_WAIT: if (dmem_ack) state_next = ST_IDLE;
      default: state_next = ST_IDLE;
    endcase
  end

  // Outputs are forced low during reset so an abandoned access drops at once.
  always_comb begin
    dmem_req     = 1'b0;
    mem_stall    = 1'b0;
    mem_misalign = 1'b0;
    if (!reset) begin
      case (state)
        ST_IDLE: begin
          if (access) begin
            if (misalign_req) begin
              mem_misalign = 1'b1;
            end else begin
              dmem_req  = 1'b1;
              mem_stall = !dmem_ack;
            end
          end
        end
        ST_WAIT: begin
          dmem_req  = 1'b1;
          mem_stall = !dmem_ack;
        end
        default: ;
      endcase
    end
  end

  // An ack only counts while a request is actually on the bus.
  assign done = dmem_req & dmem_ack;

endmodule

// File: rtl/stage_memory.sv
// Pipeline MEM stage: drives the data-memory bus and holds the MEM/WB register.
// Optional misaligned-access trapping is enabled with `define MEM_MISALIGN_EN.
module stage_memory
  import core_pkg::*;
(
  input  logic        clk,
  input  logic        reset,
  input  logic        wb_clear,
  input  logic        mem_reg_write,
  input  logic        mem_mem_write,
  input  logic        mem_mem_read,
  input  logic [1:0]  mem_result_src,
  input  logic [31:0] mem_alu_result,
  input  logic [31:0] mem_write_data,
  input  logic [31:0] mem_pc_plus_4,
  input  logic [31:0] mem_imm_ext,
  input  logic [4:0]  mem_rd,
  output logic        dmem_req,
  output logic        dmem_we,
  output logic [31:0] dmem_addr,
  output logic [31:0] dmem_wdata,
  input  logic [31:0] dmem_rdata,
  input  logic        dmem_ack,
  output logic        mem_stall,
  output logic        mem_misalign,
  output logic        wb_reg_write,
  output logic [1:0]  wb_result_src,
  output logic [31:0] wb_alu_result,
  output logic [31:0] wb_read_data,
  output logic [31:0] wb_pc_plus_4,
  output logic [31:0] wb_imm_ext,
  output logic [4:0]  wb_rd
);

  logic access;
  logic misalign_req;
  logic done;

  assign access     = mem_mem_read | mem_mem_write;
  assign dmem_addr  = mem_alu_result;
  assign dmem_wdata = mem_write_data;
  assign dmem_we    = mem_mem_write;

`ifdef MEM_MISALIGN_EN
  assign misalign_req = access & (mem_alu_result[1:0] != 2'b00);
`else
  assign misalign_req = 1'b0;
`endif

  dmem_ctrl u_dmem_ctrl (
    .clk          (clk),
    .reset        (reset),
    .access       (access),
    .misalign_req (misalign_req),
    .dmem_ack     (dmem_ack),
    .dmem_req     (dmem_req),
    .mem_stall    (mem_stall),
    .mem_misalign (mem_misalign),
    .done         (done)
  );

  // Reset, wb_clear and stall all load the same all-zero bubble.
  always_ff @(posedge clk) begin
    if (reset || wb_clear || mem_stall) begin
      wb_reg_write  <= 1'b0;
      wb_result_src <= '0;
      wb_alu_result <= '0;
      wb_read_data  <= '0;
      wb_pc_plus_4  <= '0;
      wb_imm_ext    <= '0;
      wb_rd         <= '0;
    end else begin
      wb_reg_write  <= mem_reg_write & ~mem_misalign;
      wb_result_src <= mem_result_src;
      wb_alu_result <= mem_alu_result;
      wb_pc_plus_4  <= mem_pc_plus_4;
      wb_imm_ext    <= mem_imm_ext;
      wb_rd         <= mem_rd;
      if (done && mem_mem_read) wb_read_data <= dmem_rdata;
    end
  end

endmodule

// File: tb/tb_stage_memory.sv
// Directed self-checking bench for stage_memory (honours MEM_MISALIGN_EN).
module tb_stage_memory;
  import core_pkg::*;

  logic        clk = 1'b0;
  logic        reset, wb_clear;
  logic        mem_reg_write, mem_mem_write, mem_mem_read;
  logic [1:0]  mem_result_src;
  logic [31:0] mem_alu_result, mem_write_data, mem_pc_plus_4, mem_imm_ext;
  logic [4:0]  mem_rd;
  logic        dmem_req, dmem_we;
  logic [31:0] dmem_addr, dmem_wdata, dmem_rdata;
  logic        dmem_ack, mem_stall, mem_misalign;
  logic        wb_reg_write;
  logic [1:0]  wb_result_src;
  logic [31:0] wb_alu_result, wb_read_data, wb_pc_plus_4, wb_imm_ext;
  logic [4:0]  wb_rd;

  int unsigned total = 0;
  int unsigned bad   = 0;
  int unsigned stall_cycles;

  always #5 clk = ~clk;

  stage_memory dut (
    .clk(clk), .reset(reset), .wb_clear(wb_clear),
    .mem_reg_write(mem_reg_write), .mem_mem_write(mem_mem_write),
    .mem_mem_read(mem_mem_read), .mem_result_src(mem_result_src),
    .mem_alu_result(mem_alu_result), .mem_write_data(mem_write_data),
    .mem_pc_plus_4(mem_pc_plus_4), .mem_imm_ext(mem_imm_ext), .mem_rd(mem_rd),
    .dmem_req(dmem_req), .dmem_we(dmem_we), .dmem_addr(dmem_addr),
    .dmem_wdata(dmem_wdata), .dmem_rdata(dmem_rdata), .dmem_ack(dmem_ack),
    .mem_stall(mem_stall), .mem_misalign(mem_misalign),
    .wb_reg_write(wb_reg_write), .wb_result_src(wb_result_src),
    .wb_alu_result(wb_alu_result), .wb_read_data(wb_read_data),
    .wb_pc_plus_4(wb_pc_plus_4), .wb_imm_ext(wb_imm_ext), .wb_rd(wb_rd)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got=0x%08h expected=0x%08h", tag, got, exp);
    end
  endtask

  task automatic idle_inputs();
    wb_clear = 0; mem_reg_write = 0; mem_mem_write = 0; mem_mem_read = 0;
    mem_result_src = RES_ALU; mem_alu_result = '0; mem_write_data = '0;
    mem_pc_plus_4 = '0; mem_imm_ext = '0; mem_rd = '0;
    dmem_rdata = '0; dmem_ack = 0;
  endtask

  task automatic check_wb_zero(input string tag);
    check({tag, ".reg_write"}, 32'(wb_reg_write), 0);
    check({tag, ".rd"},        32'(wb_rd), 0);
    check({tag, ".src"},       32'(wb_result_src), 0);
    check({tag, ".alu"},       wb_alu_result, 0);
    check({tag, ".rdata"},     wb_read_data, 0);
    check({tag, ".pc4"},       wb_pc_plus_4, 0);
    check({tag, ".imm"},       wb_imm_ext, 0);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: got=timeout expected=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    reset = 1; idle_inputs();
    repeat (2) @(posedge clk);
    #1;
    check("rst.req", 32'(dmem_req), 0);
    check("rst.stall", 32'(mem_stall), 0);
    check("rst.misalign", 32'(mem_misalign), 0);
    check_wb_zero("rst.wb");

    // non-memory op
    @(negedge clk);
    reset = 0; idle_inputs();
    mem_reg_write = 1; mem_alu_result = 32'h55; mem_rd = 5'd7;
    mem_pc_plus_4 = 32'h1004; mem_imm_ext = 32'h9;
    #1;
    check("alu.req", 32'(dmem_req), 0);
    check("alu.stall", 32'(mem_stall), 0);
    @(posedge clk); #1;
    check("alu.wb_alu", wb_alu_result, 32'h55);
    check("alu.wb_rd", 32'(wb_rd), 7);
    check("alu.wb_regw", 32'(wb_reg_write), 1);
    check("alu.wb_pc4", wb_pc_plus_4, 32'h1004);
    check("alu.wb_imm", wb_imm_ext, 32'h9);

    // zero-wait load
    @(negedge clk);
    idle_inputs();
    mem_reg_write = 1; mem_mem_read = 1; mem_result_src = RES_LOAD;
    mem_alu_result = 32'h100; mem_rd = 5'd5; dmem_ack = 1; dmem_rdata = 32'hDEADBEEF;
    #1;
    check("ld0.req", 32'(dmem_req), 1);
    check("ld0.stall", 32'(mem_stall), 0);
    check("ld0.addr", dmem_addr, 32'h100);
    check("ld0.we", 32'(dmem_we), 0);
    @(posedge clk); #1;
    check("ld0.wb_rdata", wb_read_data, 32'hDEADBEEF);
    check("ld0.wb_regw", 32'(wb_reg_write), 1);
    check("ld0.wb_rd", 32'(wb_rd), 5);
    check("ld0.wb_src", 32'(wb_result_src), 32'(RES_LOAD));

    // stray ack with no request: ignored, read data held
    @(negedge clk);
    idle_inputs();
    mem_reg_write = 1; mem_alu_result = 32'h77; mem_rd = 5'd3;
    dmem_ack = 1; dmem_rdata = 32'hBAD0BAD0;
    #1;
    check("stray.req", 32'(dmem_req), 0);
    @(posedge clk); #1;
    check("stray.wb_rdata", wb_read_data, 32'hDEADBEEF);
    check("stray.wb_alu", wb_alu_result, 32'h77);

    // three-wait store
    @(negedge clk);
    idle_inputs();
    mem_mem_write = 1; mem_alu_result = 32'h200; mem_write_data = 32'h12345678;
    mem_rd = 5'd9; mem_imm_ext = 32'h44;
    stall_cycles = 0;
    for (int i = 0; i < 4; i++) begin
      if (i > 0) @(negedge clk);
      dmem_ack = (i == 3);
      #1;
      if (mem_stall) stall_cycles++;
      check("st.req", 32'(dmem_req), 1);
      check("st.addr", dmem_addr, 32'h200);
      check("st.wdata", dmem_wdata, 32'h12345678);
      check("st.we", 32'(dmem_we), 1);
      @(posedge clk); #1;
      check("st.wb_alu", wb_alu_result, (i == 3) ? 32'h200 : 32'h0);
      check("st.wb_rd", 32'(wb_rd), (i == 3) ? 32'd9 : 32'd0);
      check("st.wb_regw", 32'(wb_reg_write), 0);
    end
    check("st.stall_cycles", stall_cycles, 3);

    // wb_clear during a load ack
    @(negedge clk);
    idle_inputs();
    mem_reg_write = 1; mem_mem_read = 1; mem_result_src = RES_LOAD;
    mem_alu_result = 32'h300; mem_rd = 5'd4; dmem_ack = 1; dmem_rdata = 32'hCAFEF00D;
    wb_clear = 1;
    #1;
    check("clr.req", 32'(dmem_req), 1);
    check("clr.stall", 32'(mem_stall), 0);
    @(posedge clk); #1;
    check_wb_zero("clr.wb");
    @(negedge clk);
    idle_inputs();
    #1;
    check("clr.idle_req", 32'(dmem_req), 0);
    @(posedge clk);

    // reset while waiting, late ack ignored
    @(negedge clk);
    idle_inputs();
    mem_reg_write = 1; mem_mem_read = 1; mem_alu_result = 32'h400; mem_rd = 5'd6;
    #1;
    check("rw.stall", 32'(mem_stall), 1);
    @(posedge clk);
    @(negedge clk);
    reset = 1;
    #1;
    check("rw.req_in_reset", 32'(dmem_req), 0);
    @(posedge clk); #1;
    check_wb_zero("rw.wb");
    @(negedge clk);
    reset = 0; idle_inputs();
    dmem_ack = 1; dmem_rdata = 32'h11111111;
    #1;
    check("rw.req_after", 32'(dmem_req), 0);
    check("rw.stall_after", 32'(mem_stall), 0);
    @(posedge clk); #1;
    check("rw.wb_rdata", wb_read_data, 0);
    check("rw.wb_regw", 32'(wb_reg_write), 0);

    // load at misaligned address 0x102
    @(negedge clk);
    idle_inputs();
    mem_reg_write = 1; mem_mem_read = 1; mem_result_src = RES_LOAD;
    mem_alu_result = 32'h102; mem_rd = 5'd8; dmem_ack = 1; dmem_rdata = 32'hA5A5A5A5;
    #1;
    check("mis.stall", 32'(mem_stall), 0);
`ifdef MEM_MISALIGN_EN
    check("mis.req", 32'(dmem_req), 0);
    check("mis.pulse", 32'(mem_misalign), 1);
    @(posedge clk); #1;
    check("mis.wb_regw", 32'(wb_reg_write), 0);
    check("mis.wb_rdata", wb_read_data, 0);
    @(negedge clk);
    idle_inputs();
    #1;
    check("mis.pulse_end", 32'(mem_misalign), 0);
`else
    check("mis.req", 32'(dmem_req), 1);
    check("mis.addr", dmem_addr, 32'h102);
    check("mis.pulse", 32'(mem_misalign), 0);
    @(posedge clk); #1;
    check("mis.wb_regw", 32'(wb_reg_write), 1);
    check("mis.wb_rdata", wb_read_data, 32'hA5A5A5A5);
`endif

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
